// File: rtl/combi_pkg.sv
// rtl/combi_pkg.sv - shared arbiter state, owner and access-size types
package combi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory buses around the arbiter
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_misalign;

  logic        stall_f;
  logic        stall_m;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // master: the arbiter itself; slave: pipeline stages plus memory
  modport master (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, d_rdata, d_ready, d_misalign, stall_f, stall_m,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, d_rdata, d_ready, d_misalign, stall_f, stall_m,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte enables, store lane replication and misalign detect
module mem_lane_align
  import combi_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = 4'hF;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (size_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      MEM_HALF: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      // word and the unused 2'b11 code both behave as a full word
      default: misalign_o = |addr_lo_i;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between fetch and data stages
// Data has priority; a streak counter forces a fetch grant after MAX_DATA_STREAK data grants.
module mem_arbiter
  import combi_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  arb_state_t  state_q;
  arb_owner_t  owner_q;
  logic [3:0]  streak_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [31:0] if_rdata_q, d_rdata_q;
  logic        if_ready_q, d_ready_q, d_misalign_q;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic        lane_misalign;
  logic        grant_d;
  logic        unused_if_addr_lo;

  mem_lane_align u_lane_align (
    .size_i     (bus.d_size),
    .addr_lo_i  (bus.d_addr[1:0]),
    .wdata_i    (bus.d_wdata),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .misalign_o (lane_misalign)
  );

  assign grant_d = bus.d_req & ~(bus.if_req & (streak_q == STREAK_MAX));
  assign unused_if_addr_lo = ^bus.if_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_FETCH;
      streak_q     <= 4'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      if_rdata_q   <= 32'd0;
      d_rdata_q    <= 32'd0;
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      d_misalign_q <= 1'b0;
    end else begin
      if_ready_q   <= 1'b0;
      d_ready_q    <= 1'b0;
      d_misalign_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            owner_q  <= OWN_DATA;
            // grant_d already excludes streak == max while a fetch waits, so +1 saturates
            streak_q <= bus.if_req ? streak_q + 4'd1 : 4'd0;
            if (lane_misalign) begin
              state_q      <= RESP;
              d_ready_q    <= 1'b1;
              d_misalign_q <= 1'b1;
              d_rdata_q    <= 32'd0;
            end else begin
              state_q     <= MEM;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= {bus.d_addr[31:2], 2'b00};
              mem_be_q    <= lane_be;
              mem_wdata_q <= lane_wdata;
            end
          end else if (bus.if_req) begin
            owner_q     <= OWN_FETCH;
            streak_q    <= 4'd0;
            state_q     <= MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {bus.if_addr[31:2], 2'b00};
            mem_be_q    <= 4'hF;
            mem_wdata_q <= 32'd0;
          end
        end
        MEM: begin
          if (bus.mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (owner_q == OWN_DATA) begin
              d_rdata_q <= bus.mem_rdata;
              d_ready_q <= 1'b1;
            end else begin
              if_rdata_q <= bus.mem_rdata;
              if_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_ready    = d_ready_q;
  assign bus.d_misalign = d_misalign_q;
  assign bus.stall_f    = bus.if_req & ~if_ready_q;
  assign bus.stall_m    = bus.d_req & ~d_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        mis;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } mtx_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic clk;
  logic rst;
  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_DATA_STREAK(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  rsp_t        rsp_q[$];
  mtx_t        mtx_q[$];
  logic [31:0] fq[$];
  dreq_t       dq[$];

  int  ws = 0;
  bit  resp_en = 1'b1;
  bit  manual_ack = 1'b0;
  int  f_cyc, d_cyc;
  int  mem_req_cycles = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return addr ^ 32'h5A5A_0000;
  endfunction

  function automatic rsp_t mk_rsp(input logic is_d, input logic [31:0] rdata, input logic mis);
    rsp_t r;
    r.is_d = is_d; r.rdata = rdata; r.mis = mis;
    return r;
  endfunction

  function automatic mtx_t mk_mtx(input logic [31:0] addr, input logic [3:0] be,
                                  input logic we, input logic [31:0] wdata);
    mtx_t m;
    m.addr = addr; m.be = be; m.we = we; m.wdata = wdata;
    return m;
  endfunction

  function automatic dreq_t mk_dreq(input logic we, input logic [1:0] size,
                                    input logic [31:0] addr, input logic [31:0] wdata);
    dreq_t d;
    d.we = we; d.size = size; d.addr = addr; d.wdata = wdata;
    return d;
  endfunction

  task automatic exp_fetch(input logic [31:0] addr);
    mtx_q.push_back(mk_mtx(addr, 4'hF, 1'b0, 32'd0));
    rsp_q.push_back(mk_rsp(1'b0, mem_model(addr), 1'b0));
  endtask

  task automatic exp_load(input logic [31:0] addr);
    mtx_q.push_back(mk_mtx(addr, 4'hF, 1'b0, 32'd0));
    rsp_q.push_back(mk_rsp(1'b1, mem_model(addr), 1'b0));
  endtask

  // sole driver of the memory-side inputs
  initial begin
    int wcnt;
    wcnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (!resp_en) begin
        bus.mem_ack   = manual_ack;
        bus.mem_rdata = 32'h0BAD0BAD;
        wcnt = 0;
      end else if (bus.mem_req && wcnt >= ws) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_model(bus.mem_addr);
        wcnt = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        wcnt = bus.mem_req ? wcnt + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_req) mem_req_cycles++;
    if (bus.mem_req && bus.mem_ack) begin
      if (mtx_q.size() == 0) check_eq("mem_q_underflow", mtx_q.size(), 1);
      else begin
        mtx_t m;
        m = mtx_q.pop_front();
        check_eq("mem_addr", bus.mem_addr, m.addr);
        check_eq("mem_be", {28'd0, bus.mem_be}, {28'd0, m.be});
        check_eq("mem_we", {31'd0, bus.mem_we}, {31'd0, m.we});
        check_eq("mem_wdata", bus.mem_wdata, m.wdata);
      end
    end
    if (bus.if_ready || bus.d_ready) begin
      check_eq("ready_overlap", {31'd0, bus.if_ready & bus.d_ready}, 32'd0);
      if (rsp_q.size() == 0) check_eq("rsp_q_underflow", rsp_q.size(), 1);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        check_eq("rsp_owner", {31'd0, bus.d_ready}, {31'd0, r.is_d});
        check_eq("rsp_rdata", r.is_d ? bus.d_rdata : bus.if_rdata, r.rdata);
        check_eq("rsp_misalign", {31'd0, bus.d_misalign}, {31'd0, r.mis});
      end
    end
    if (bus.d_misalign) check_eq("misalign_without_ready", {31'd0, bus.d_ready}, 32'd1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_traffic(input int max_cyc);
    int cyc;
    logic fd, dd;
    dreq_t dr;
    cyc = 0; f_cyc = -1; d_cyc = -1;
    while ((fq.size() != 0 || dq.size() != 0 || bus.if_req || bus.d_req) && cyc < max_cyc) begin
      if (!bus.if_req && fq.size() != 0) begin
        bus.if_req  = 1'b1;
        bus.if_addr = fq.pop_front();
      end
      if (!bus.d_req && dq.size() != 0) begin
        dr = dq.pop_front();
        bus.d_req = 1'b1; bus.d_we = dr.we; bus.d_size = dr.size;
        bus.d_addr = dr.addr; bus.d_wdata = dr.wdata;
      end
      @(negedge clk);
      fd = bus.if_ready;
      dd = bus.d_ready;
      if (fd && f_cyc < 0) f_cyc = cyc;
      if (dd && d_cyc < 0) d_cyc = cyc;
      tick();
      if (fd) bus.if_req = 1'b0;
      if (dd) bus.d_req = 1'b0;
      cyc++;
    end
    check_eq("traffic_timeout", {31'd0, cyc < max_cyc}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b10;
    bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    repeat (3) tick();
    @(negedge clk);
    check_eq("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check_eq("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_if_rdata", bus.if_rdata, 32'd0);
    check_eq("rst_d_rdata", bus.d_rdata, 32'd0);
    check_eq("rst_readys", {29'd0, bus.if_ready, bus.d_ready, bus.d_misalign}, 32'd0);
    tick();
    rst = 1'b0;

    // fetch only, zero wait
    exp_fetch(32'h100);
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    @(negedge clk);
    check_eq("f0_stall_f", {31'd0, bus.stall_f}, 32'd1);
    check_eq("f0_mem_req", {31'd0, bus.mem_req}, 32'd0);
    tick(); @(negedge clk);
    check_eq("f1_mem_req", {31'd0, bus.mem_req}, 32'd1);
    check_eq("f1_mem_addr", bus.mem_addr, 32'h100);
    check_eq("f1_mem_be", {28'd0, bus.mem_be}, 32'hF);
    check_eq("f1_stall_f", {31'd0, bus.stall_f}, 32'd1);
    tick(); @(negedge clk);
    check_eq("f2_if_ready", {31'd0, bus.if_ready}, 32'd1);
    check_eq("f2_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    check_eq("f2_stall_f", {31'd0, bus.stall_f}, 32'd0);
    check_eq("f2_stall_m", {31'd0, bus.stall_m}, 32'd0);
    tick();
    bus.if_req = 1'b0;

    // simultaneous requests, data first
    exp_load(32'h2000);
    exp_fetch(32'h104);
    dq.push_back(mk_dreq(1'b0, 2'b10, 32'h2000, 32'd0));
    fq.push_back(32'h104);
    run_traffic(40);
    check_eq("sim_d_ready_cyc", d_cyc, 32'd2);
    check_eq("sim_f_ready_cyc", f_cyc, 32'd5);

    // starvation bound with streak limit 2: D D F D D F
    exp_load(32'h3000); exp_load(32'h3004); exp_fetch(32'h200);
    exp_load(32'h3008); exp_load(32'h300C); exp_fetch(32'h204);
    for (int i = 0; i < 4; i++) dq.push_back(mk_dreq(1'b0, 2'b10, 32'h3000 + 32'(4 * i), 32'd0));
    fq.push_back(32'h200); fq.push_back(32'h204);
    run_traffic(60);

    // stores: byte lane 3, then half upper with two wait states
    mtx_q.push_back(mk_mtx(32'h2000, 4'b1000, 1'b1, 32'hABABABAB));
    rsp_q.push_back(mk_rsp(1'b1, mem_model(32'h2000), 1'b0));
    dq.push_back(mk_dreq(1'b1, 2'b00, 32'h2003, 32'h000000AB));
    run_traffic(20);
    check_eq("st_byte_ready_cyc", d_cyc, 32'd2);
    ws = 2;
    mtx_q.push_back(mk_mtx(32'h2000, 4'b1100, 1'b1, 32'h12341234));
    rsp_q.push_back(mk_rsp(1'b1, mem_model(32'h2000), 1'b0));
    dq.push_back(mk_dreq(1'b1, 2'b01, 32'h2002, 32'h00001234));
    run_traffic(20);
    check_eq("st_half_ready_cyc", d_cyc, 32'd4);
    ws = 0;
    mtx_q.push_back(mk_mtx(32'h2004, 4'b0010, 1'b1, 32'h5C5C5C5C));
    rsp_q.push_back(mk_rsp(1'b1, mem_model(32'h2004), 1'b0));
    dq.push_back(mk_dreq(1'b1, 2'b00, 32'h2005, 32'hFFFFFF5C));
    run_traffic(20);

    // misaligned word load and half store
    mem_req_cycles = 0;
    rsp_q.push_back(mk_rsp(1'b1, 32'd0, 1'b1));
    dq.push_back(mk_dreq(1'b0, 2'b10, 32'h2001, 32'd0));
    run_traffic(20);
    check_eq("mis_word_ready_cyc", d_cyc, 32'd1);
    rsp_q.push_back(mk_rsp(1'b1, 32'd0, 1'b1));
    dq.push_back(mk_dreq(1'b1, 2'b01, 32'h2003, 32'h0000BEEF));
    run_traffic(20);
    check_eq("mis_mem_req_cycles", mem_req_cycles, 32'd0);

    // reset while waiting on a slow memory
    resp_en = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    tick(); @(negedge clk);
    check_eq("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    check_eq("rst_abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
    manual_ack = 1'b1;
    tick(); @(negedge clk);
    check_eq("late_ack_if_ready", {31'd0, bus.if_ready}, 32'd0);
    manual_ack = 1'b0;
    tick(); @(negedge clk);
    check_eq("late_ack_if_ready2", {31'd0, bus.if_ready}, 32'd0);
    tick();
    resp_en = 1'b1;
    exp_fetch(32'h500);
    fq.push_back(32'h500);
    run_traffic(20);
    check_eq("post_rst_fetch_cyc", f_cyc, 32'd2);

    check_eq("rsp_q_empty", rsp_q.size(), 32'd0);
    check_eq("mem_q_empty", mtx_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
